muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: SIZE, default 32, operand/result width in bits; legal values even and >= 4.
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 RST_N  input  1  asynchronous active-low reset.
REQ-004 START  input  1  request strobe, sampled only in IDLE.
REQ-005 FLUSH  input  1  abandons any operation in progress.
REQ-006 OPERATION  input  3  muldiv_op_t: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-007 A  input  SIZE  operand 1 (multiplicand / dividend).
REQ-008 B  input  SIZE  operand 2 (multiplier / divisor).
REQ-009 BUSY  output  1  high while in CALC or DONE state.
REQ-010 DONE  output  1  one-cycle pulse, RESULT valid.
REQ-011 RESULT  output  SIZE  registered result, held until the next accepted START.
REQ-012 ZERO  output  1  high when RESULT == 0, combinational from RESULT.

Function
REQ-013 States: IDLE, CALC, DONE; IDLE + START -> CALC; CALC with iteration counter == 0 -> DONE; DONE -> IDLE unconditionally.
REQ-014 In IDLE with START high, the unit SHALL latch A, B and OPERATION and load the counter with SIZE-1; later changes to A/B/OPERATION are ignored.
REQ-015 Each CALC cycle performs exactly one iteration: one shift-add step (multiply) or one restoring subtract-shift step (divide) on operand magnitudes.
REQ-016 Latency is fixed: DONE is high in the cycle SIZE+1 edges after the edge that accepted START, for every operation including special cases.
REQ-017 START while BUSY is ignored; a new START is accepted in the first IDLE cycle after DONE, so back-to-back throughput is one operation per SIZE+2 cycles.
REQ-018 MUL returns product bits [SIZE-1:0]; MULH/MULHSU/MULHU return bits [2*SIZE-1:SIZE] of the signed*signed, signed A * unsigned B, and unsigned*unsigned products.
REQ-019 Signed operations convert operands to magnitudes at START and negate the 2*SIZE-bit product, quotient or remainder at the end as needed; quotient sign = sign(A) XOR sign(B); remainder sign = sign(A).
REQ-020 Divide by zero: DIV/DIVU return all ones, REM/REMU return A.
REQ-021 Signed overflow (A = most negative, B = -1): DIV returns A, REM returns 0.
REQ-022 FLUSH high in any state SHALL force IDLE on the next edge with no DONE pulse and RESULT unchanged; FLUSH has priority over START in the same cycle.
REQ-023 RESULT updates only on the edge entering DONE.

Reset
REQ-024 RST_N low SHALL asynchronously force state IDLE, counter 0, BUSY 0, DONE 0, RESULT 0 (ZERO therefore 1), internal operand/accumulator registers 0.
REQ-025 Reset mid-operation discards the operation; no DONE follows reset release.

Structure
REQ-026 muldiv_op_t (3-bit enum) SHALL live in the shared operation-type package beside the ALU operation encoding.
REQ-027 Single module; no sub-module; the mul and div datapaths share the 2*SIZE-bit accumulator and the counter.

Verification (SIZE=32)
REQ-028 MUL A=7, B=0xFFFFFFFD -> RESULT 0xFFFFFFEB, DONE exactly 33 edges after START, BUSY high throughout.
REQ-029 MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU A=0xFFFFFFFF, B=0xFFFFFFFF -> 0xFFFFFFFF.
REQ-030 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
REQ-031 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0 with ZERO=1; both at the normal 33-cycle latency.
REQ-032 START re-pulsed with new operands at cycle 10 of an operation -> ignored, original result returned; FLUSH at cycle 10 -> IDLE next cycle, no DONE, RESULT keeps its previous value.
REQ-033 RST_N low at cycle 15 -> BUSY=0, RESULT=0 immediately; after release, no DONE until a new START.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Operation encodings shared by the integer execution units (ALU and multiply/divide).
package muldiv_unit_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_t;

    // Bit 2 set selects the divide family.
    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } muldiv_op_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: one shift-add or restoring subtract step per cycle,
// sharing a 2*SIZE accumulator and iteration counter between both datapaths.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned SIZE = 32
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            START,
    input  logic            FLUSH,
    input  muldiv_op_t      OPERATION,
    input  logic [SIZE-1:0] A,
    input  logic [SIZE-1:0] B,
    output logic            BUSY,
    output logic            DONE,
    output logic [SIZE-1:0] RESULT,
    output logic            ZERO
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int unsigned CW = $clog2(SIZE);

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              fix_q, fix_d;
    muldiv_op_t        op_q, op_d;
    logic [SIZE-1:0]   a_q, a_d;
    logic              neg_q, neg_d;
    logic [SIZE-1:0]   mcand_q, mcand_d;
    logic [2*SIZE-1:0] acc_q, acc_d;
    logic [SIZE-1:0]   result_q, result_d;

    logic              a_sgn, b_sgn, a_neg, b_neg, start_neg;
    logic [SIZE-1:0]   a_mag, b_mag;
    logic [SIZE:0]     mul_sum, rem_sh;
    logic [SIZE-1:0]   rem_sub;
    logic              ge;
    logic [2*SIZE-1:0] iter_acc, prod_fix;
    logic [SIZE-1:0]   quo, rem, fin_res;

    always_comb begin
        a_sgn     = (OPERATION == MUL) || (OPERATION == MULH) || (OPERATION == MULHSU) ||
                    (OPERATION == DIV) || (OPERATION == REM);
        b_sgn     = (OPERATION == MUL) || (OPERATION == MULH) ||
                    (OPERATION == DIV) || (OPERATION == REM);
        a_neg     = a_sgn & A[SIZE-1];
        b_neg     = b_sgn & B[SIZE-1];
        a_mag     = a_neg ? -A : A;
        b_mag     = b_neg ? -B : B;
        start_neg = ((OPERATION == REM) || (OPERATION == REMU)) ? a_neg : (a_neg ^ b_neg);
    end

    // Multiply keeps the multiplier in the low half and shifts right; divide keeps the
    // partial remainder in the high half and shifts quotient bits in from the right.
    always_comb begin
        mul_sum = {1'b0, acc_q[2*SIZE-1:SIZE]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        rem_sh  = acc_q[2*SIZE-1:SIZE-1];
        ge      = rem_sh >= {1'b0, mcand_q};
        rem_sub = rem_sh[SIZE-1:0] - mcand_q;
        if (op_q[2]) begin
            iter_acc = {(ge ? rem_sub : rem_sh[SIZE-1:0]), acc_q[SIZE-2:0], ge};
        end else begin
            iter_acc = {mul_sum, acc_q[SIZE-1:1]};
        end
    end

    always_comb begin
        prod_fix = neg_q ? -acc_q : acc_q;
        quo      = acc_q[SIZE-1:0];
        rem      = acc_q[2*SIZE-1:SIZE];
        fin_res  = '0;
        case (op_q)
            MUL:                 fin_res = prod_fix[SIZE-1:0];
            MULH, MULHSU, MULHU: fin_res = prod_fix[2*SIZE-1:SIZE];
            DIV, DIVU:           fin_res = (mcand_q == '0) ? '1 : (neg_q ? -quo : quo);
            REM, REMU:           fin_res = (mcand_q == '0) ? a_q : (neg_q ? -rem : rem);
            default:             fin_res = '0;
        endcase
    end

    // After the last iteration one extra CALC cycle applies the sign/special-case
    // correction from the registered accumulator, giving a fixed SIZE+1 latency.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fix_d    = fix_q;
        op_d     = op_q;
        a_d      = a_q;
        neg_d    = neg_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (!FLUSH && START) begin
                    state_d = S_CALC;
                    cnt_d   = CW'(SIZE - 1);
                    fix_d   = 1'b0;
                    op_d    = OPERATION;
                    a_d     = A;
                    neg_d   = start_neg;
                    if (OPERATION[2]) begin
                        mcand_d = b_mag;
                        acc_d   = {{SIZE{1'b0}}, a_mag};
                    end else begin
                        mcand_d = a_mag;
                        acc_d   = {{SIZE{1'b0}}, b_mag};
                    end
                end
            end
            S_CALC: begin
                if (FLUSH) begin
                    state_d = S_IDLE;
                end else if (!fix_q) begin
                    acc_d = iter_acc;
                    if (cnt_q == '0) begin
                        fix_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end else begin
                    result_d = fin_res;
                    state_d  = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            fix_q    <= 1'b0;
            op_q     <= MUL;
            a_q      <= '0;
            neg_q    <= 1'b0;
            mcand_q  <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            fix_q    <= fix_d;
            op_q     <= op_d;
            a_q      <= a_d;
            neg_q    <= neg_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign BUSY   = (state_q == S_CALC) || (state_q == S_DONE);
    assign DONE   = (state_q == S_DONE);
    assign RESULT = result_q;
    assign ZERO   = (result_q == '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at SIZE=32.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        flush;
    muldiv_op_t  op_s;
    logic [31:0] a_s;
    logic [31:0] b_s;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        zero;

    int total;
    int bad;

    muldiv_unit #(.SIZE(32)) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .START     (start),
        .FLUSH     (flush),
        .OPERATION (op_s),
        .A         (a_s),
        .B         (b_s),
        .BUSY      (busy),
        .DONE      (done),
        .RESULT    (result),
        .ZERO      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one operation, scrambles the inputs after acceptance, and waits (bounded)
    // for DONE; lat counts edges after the accepting edge. Leaves the unit in IDLE.
    task automatic run_op(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic res_zero,
                          output int lat, output logic busy_ok);
        @(negedge clk);
        op_s = op; a_s = a; b_s = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a_s = ~a; b_s = ~b; op_s = MULHU;
        lat = 0;
        busy_ok = 1'b1;
        while (!done && lat < 100) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        res = result;
        res_zero = zero;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; op_s = MUL; a_s = '0; b_s = '0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL rst_result got=%h exp=0", result); end
        total++; if (zero !== 1'b1) begin bad++; $display("FAIL rst_zero got=%b exp=1", zero); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_rel_busy got=%b exp=0", busy); end
    endtask

    task automatic test_mul;
        logic [31:0] r; logic z; int lat; logic bok;
        run_op(MUL, 32'd7, 32'hFFFF_FFFD, r, z, lat, bok);
        total++; if (r !== 32'hFFFF_FFEB) begin bad++; $display("FAIL mul_res got=%h exp=ffffffeb", r); end
        total++; if (lat !== 33) begin bad++; $display("FAIL mul_lat got=%0d exp=33", lat); end
        total++; if (bok !== 1'b1) begin bad++; $display("FAIL mul_busy got=%b exp=1", bok); end
        total++; if (z !== 1'b0) begin bad++; $display("FAIL mul_zero got=%b exp=0", z); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL mul_done_pulse got=%b exp=0", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mul_idle_busy got=%b exp=0", busy); end
        run_op(MUL, 32'd6, 32'd7, r, z, lat, bok);
        total++; if (r !== 32'd42) begin bad++; $display("FAIL mul_small got=%h exp=0000002a", r); end
    endtask

    task automatic test_mulh;
        logic [31:0] r; logic z; int lat; logic bok;
        run_op(MULH, 32'h8000_0000, 32'h8000_0000, r, z, lat, bok);
        total++; if (r !== 32'h4000_0000) begin bad++; $display("FAIL mulh got=%h exp=40000000", r); end
        run_op(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, z, lat, bok);
        total++; if (r !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mulhu got=%h exp=fffffffe", r); end
        run_op(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, z, lat, bok);
        total++; if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mulhsu got=%h exp=ffffffff", r); end
        total++; if (lat !== 33) begin bad++; $display("FAIL mulhsu_lat got=%0d exp=33", lat); end
        run_op(MULH, 32'hFFFF_FFFF, 32'd5, r, z, lat, bok);
        total++; if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mulh_neg got=%h exp=ffffffff", r); end
    endtask

    task automatic test_div;
        logic [31:0] r; logic z; int lat; logic bok;
        run_op(DIV, 32'hFFFF_FFF9, 32'd2, r, z, lat, bok);
        total++; if (r !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div got=%h exp=fffffffd", r); end
        run_op(REM, 32'hFFFF_FFF9, 32'd2, r, z, lat, bok);
        total++; if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rem got=%h exp=ffffffff", r); end
        run_op(DIVU, 32'd5, 32'd0, r, z, lat, bok);
        total++; if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL divu_zero got=%h exp=ffffffff", r); end
        total++; if (lat !== 33) begin bad++; $display("FAIL divu_zero_lat got=%0d exp=33", lat); end
        run_op(REMU, 32'd5, 32'd0, r, z, lat, bok);
        total++; if (r !== 32'd5) begin bad++; $display("FAIL remu_zero got=%h exp=00000005", r); end
        run_op(DIVU, 32'd100, 32'd7, r, z, lat, bok);
        total++; if (r !== 32'd14) begin bad++; $display("FAIL divu got=%h exp=0000000e", r); end
        run_op(REMU, 32'd100, 32'd7, r, z, lat, bok);
        total++; if (r !== 32'd2) begin bad++; $display("FAIL remu got=%h exp=00000002", r); end
        run_op(DIV, 32'd5, 32'd0, r, z, lat, bok);
        total++; if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_zero got=%h exp=ffffffff", r); end
        run_op(REM, 32'hFFFF_FFF9, 32'd0, r, z, lat, bok);
        total++; if (r !== 32'hFFFF_FFF9) begin bad++; $display("FAIL rem_zero got=%h exp=fffffff9", r); end
    endtask

    task automatic test_overflow;
        logic [31:0] r; logic z; int lat; logic bok;
        run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, r, z, lat, bok);
        total++; if (r !== 32'h8000_0000) begin bad++; $display("FAIL div_ovf got=%h exp=80000000", r); end
        total++; if (lat !== 33) begin bad++; $display("FAIL div_ovf_lat got=%0d exp=33", lat); end
        run_op(REM, 32'h8000_0000, 32'hFFFF_FFFF, r, z, lat, bok);
        total++; if (r !== 32'h0) begin bad++; $display("FAIL rem_ovf got=%h exp=00000000", r); end
        total++; if (z !== 1'b1) begin bad++; $display("FAIL rem_ovf_zero got=%b exp=1", z); end
        total++; if (lat !== 33) begin bad++; $display("FAIL rem_ovf_lat got=%0d exp=33", lat); end
    endtask

    task automatic test_start_ignored;
        int n;
        @(negedge clk);
        op_s = MUL; a_s = 32'd3; b_s = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            if (n == 10) begin
                @(negedge clk);
                op_s = DIVU; a_s = 32'd100; b_s = 32'd3; start = 1'b1;
            end
            @(posedge clk); #1;
            n++;
            start = 1'b0;
        end
        total++; if (result !== 32'd15) begin bad++; $display("FAIL restart_res got=%h exp=0000000f", result); end
        total++; if (n !== 33) begin bad++; $display("FAIL restart_lat got=%0d exp=33", n); end
        @(posedge clk); #1;
    endtask

    task automatic test_flush;
        int dn;
        dn = 0;
        @(negedge clk);
        op_s = DIVU; a_s = 32'd1000; b_s = 32'd10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done) dn++;
        end
        @(negedge clk);
        flush = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b exp=0", busy); end
        total++; if (result !== 32'd15) begin bad++; $display("FAIL flush_res got=%h exp=0000000f", result); end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) dn++;
        end
        total++; if (dn !== 0) begin bad++; $display("FAIL flush_done got=%0d exp=0", dn); end
        @(negedge clk);
        flush = 1'b1; start = 1'b1; op_s = MUL; a_s = 32'd1; b_s = 32'd1;
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_prio_busy got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid;
        int dn;
        dn = 0;
        @(negedge clk);
        op_s = MUL; a_s = 32'h1234; b_s = 32'h10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mrst_busy got=%b exp=0", busy); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL mrst_result got=%h exp=0", result); end
        total++; if (zero !== 1'b1) begin bad++; $display("FAIL mrst_zero got=%b exp=1", zero); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) dn++;
        end
        total++; if (dn !== 0) begin bad++; $display("FAIL mrst_done got=%0d exp=0", dn); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] r; logic z; int lat; logic bok;
        run_op(DIV, 32'hFFFF_FF9C, 32'd7, r, z, lat, bok);
        total++; if (r !== 32'hFFFF_FFF2) begin bad++; $display("FAIL b2b_div got=%h exp=fffffff2", r); end
        run_op(REM, 32'hFFFF_FF9C, 32'd7, r, z, lat, bok);
        total++; if (r !== 32'hFFFF_FFFE) begin bad++; $display("FAIL b2b_rem got=%h exp=fffffffe", r); end
        run_op(MULHSU, 32'h8000_0000, 32'd2, r, z, lat, bok);
        total++; if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL b2b_mulhsu got=%h exp=ffffffff", r); end
        total++; if (lat !== 33) begin bad++; $display("FAIL b2b_lat got=%0d exp=33", lat); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_overflow();
        test_start_ignored();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
